mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM stage of the 5-stage RV32I core; sits between the EX/MEM pipeline register and MEM/WB.
- Non-memory instructions pass their writeback fields through combinationally.
- Loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW) run as a multi-cycle byte-serial transaction on the 8-bit RAM port.
- Raises a stall request so upstream stages hold until the transaction completes.

Parameters:
- ADDR_W, 32, byte-address width of the memory port and of mem_addr_in.

Ports:
- clk_in  in  1  clock; all state updates on rising edge.
- rst_in  in  1  reset, asynchronous, active-low.
- rdy_in  in  1  global ready; when 0, all state and registered outputs are frozen.
- rd_we_in  in  1  writeback enable from EX/MEM.
- rd_val_in  in  32  ALU result from EX/MEM.
- rd_addr_in  in  5  destination register.
- mem_op_in  in  4  0=NONE, 1=LB, 2=LH, 3=LW, 4=LBU, 5=LHU, 6=SB, 7=SH, 8=SW; 9–15 treated as NONE.
- mem_addr_in  in  ADDR_W  effective byte address.
- store_data_in  in  32  rs2 value for stores.
- mem_busy_in  in  1  arbiter grant blocked (IF owns the port this cycle).
- mem_din_in  in  8  RAM read byte; valid the cycle after its address is presented.
- mem_a_out  out  ADDR_W  registered RAM byte address.
- mem_wr_out  out  1  registered RAM write strobe.
- mem_dout_out  out  8  registered RAM write byte.
- mem_req_out  out  1  high while this stage owns the port (RUN/WAIT states).
- stall_req_out  out  1  combinational stall request to the pipeline controller.
- rd_we_out  out  1  writeback enable to MEM/WB.
- rd_val_out  out  32  writeback value to MEM/WB.
- rd_addr_out  out  5  destination register to MEM/WB.

Behaviour:
- Reset (rst_in=0, asynchronous):
  - State=IDLE, cnt=0, load buffer=0.
  - mem_a_out=0, mem_wr_out=0, mem_dout_out=0.
  - While rst_in=0, mem_req_out, stall_req_out, rd_we_out, rd_val_out and rd_addr_out are forced to 0.
- Byte count n: 1 for LB/LBU/SB, 2 for LH/LHU/SH, 4 for LW/SW. Byte k lives at address mem_addr_in+k, mod 2^ADDR_W (wraps at the top of memory). Little-endian.
- FSM states:
  - IDLE:
    - If mem_op is NONE: outputs pass through (rd_*_out = rd_*_in), stall=0, mem_wr_out=0.
    - If mem_op is load/store and mem_busy_in=1: stay in IDLE, stall=1.
    - If mem_op is load/store and mem_busy_in=0: register mem_a_out=addr, mem_wr_out=is_store, mem_dout_out=store_data[7:0]; set cnt=0; go to RUN; stall=1.
  - RUN, cycle with cnt=k:
    - Byte k's address is on the bus.
    - Load with k>=1: capture mem_din_in into buffer byte k-1.
    - If k<n-1: register address+k+1 and store byte k+1; cnt=k+1.
    - If k=n-1: clear mem_wr_out; a load goes to WAIT, a store goes to DONE.
    - stall=1, mem_req_out=1.
  - WAIT (loads only): capture mem_din_in into buffer byte n-1; go to DONE; stall=1, mem_req_out=1.
  - DONE: stall=0; mem_wr_out=0; return to IDLE.
    - Load: rd_val_out = extended buffer (LB/LH sign-extend, LBU/LHU zero-extend, LW raw); rd_we_out = rd_we_in.
    - Store: rd_val_out = rd_val_in; rd_we_out = rd_we_in.
    - EX/MEM advances on the clock edge that ends DONE.
- Latency:
  - Stall cycles on an unblocked start: loads n+2 (LB 3, LH 4, LW 6); stores n+1 (SB 2, SW 5).
  - Each mem_busy_in cycle observed in IDLE adds one cycle.
- rd_*_out are don't-care but must have rd_we_out=0 while stall_req_out=1, so MEM/WB never writes a stalled value.
- mem_busy_in is sampled only in IDLE. Once RUN is entered, the transaction completes regardless of mem_busy_in.
- rdy_in=0: no state, counter, buffer or registered-output change; combinational outputs keep following the held state.
- Reset mid-transaction: immediate abort to IDLE with mem_wr_out=0. A partially written store is not rolled back.
- Inputs are held stable by upstream while stall_req_out=1; no input change is required to be tolerated mid-transaction.

Test Plan:
- Reset then NONE op, rd_we_in=1, rd_addr_in=5, rd_val_in=0x1234 -> same cycle rd_we_out=1, rd_addr_out=5, rd_val_out=0x1234, stall 0, mem_wr_out 0.
- LW at 0x100, RAM bytes 78 56 34 12 -> mem_a_out 0x100..0x103 in consecutive cycles; stall high for 6 cycles; DONE cycle rd_val_out=0x12345678, rd_we_out=1.
- LB and LBU at 0x200 holding 0x80 -> LB gives 0xFFFFFF80, LBU gives 0x00000080; LH at 0x202 holding 0xFE 0xFF -> 0xFFFFFFFE.
- SW 0xDEADBEEF at 0xFFFFFFFE -> writes EF@0xFFFFFFFE, BE@0xFFFFFFFF, AD@0x0, DE@0x1 with mem_wr_out=1 on each; stall 5 cycles.
- mem_busy_in=1 for 3 cycles at SB start, plus rdy_in=0 for 2 cycles mid-LW -> SB start delayed 3 cycles; LW completes 2 cycles late with a correct value.
- rst_in pulled low during the 2nd byte of an SH -> all outputs 0 immediately; state IDLE after release; next LW completes normally.

Source files
------------

// File: rtl/mem_stage.sv
// MEM stage: passes ALU results through and runs loads/stores
// as byte-serial transactions on the 8-bit RAM port.
module mem_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              rd_we_in,
    input  logic [31:0]       rd_val_in,
    input  logic [4:0]        rd_addr_in,
    input  logic [3:0]        mem_op_in,
    input  logic [ADDR_W-1:0] mem_addr_in,
    input  logic [31:0]       store_data_in,
    input  logic              mem_busy_in,
    input  logic [7:0]        mem_din_in,
    output logic [ADDR_W-1:0] mem_a_out,
    output logic              mem_wr_out,
    output logic [7:0]        mem_dout_out,
    output logic              mem_req_out,
    output logic              stall_req_out,
    output logic              rd_we_out,
    output logic [31:0]       rd_val_out,
    output logic [4:0]        rd_addr_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_WAIT,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [31:0]       buf_q, buf_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic              wr_q, wr_d;
    logic [7:0]        dout_q, dout_d;

    logic        is_ld;
    logic        is_st;
    logic        sext;
    logic [1:0]  last;
    logic [1:0]  prev;
    logic [1:0]  nxt;
    logic [31:0] ext;

    // Decode the access kind, byte count (as last index) and signedness.
    always_comb begin
        is_ld = 1'b0;
        is_st = 1'b0;
        sext  = 1'b0;
        last  = 2'd0;
        case (mem_op_in)
            4'd1: begin is_ld = 1'b1; sext = 1'b1; end
            4'd2: begin is_ld = 1'b1; sext = 1'b1; last = 2'd1; end
            4'd3: begin is_ld = 1'b1; last = 2'd3; end
            4'd4: is_ld = 1'b1;
            4'd5: begin is_ld = 1'b1; last = 2'd1; end
            4'd6: is_st = 1'b1;
            4'd7: begin is_st = 1'b1; last = 2'd1; end
            4'd8: begin is_st = 1'b1; last = 2'd3; end
            default: ;
        endcase
    end

    // Sign/zero-extend the assembled load buffer.
    always_comb begin
        ext = buf_q;
        case (last)
            2'd0: ext = {{24{sext & buf_q[7]}}, buf_q[7:0]};
            2'd1: ext = {{16{sext & buf_q[15]}}, buf_q[15:0]};
            default: ext = buf_q;
        endcase
    end

    assign prev = cnt_q - 2'd1;
    assign nxt  = cnt_q + 2'd1;

    // Next-state logic for the byte-serial transaction.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        a_d     = a_q;
        wr_d    = wr_q;
        dout_d  = dout_q;
        case (state_q)
            S_IDLE: begin
                if ((is_ld || is_st) && !mem_busy_in) begin
                    a_d     = mem_addr_in;
                    wr_d    = is_st;
                    dout_d  = store_data_in[7:0];
                    cnt_d   = 2'd0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Byte k-1 arrives while byte k's address is out.
                if (is_ld && cnt_q != 2'd0)
                    buf_d[{prev, 3'b000} +: 8] = mem_din_in;
                if (cnt_q != last) begin
                    a_d    = a_q + ADDR_W'(1);
                    dout_d = store_data_in[{nxt, 3'b000} +: 8];
                    cnt_d  = nxt;
                end else begin
                    wr_d    = 1'b0;
                    state_d = is_ld ? S_WAIT : S_DONE;
                end
            end
            S_WAIT: begin
                buf_d[{last, 3'b000} +: 8] = mem_din_in;
                state_d = S_DONE;
            end
            S_DONE: begin
                wr_d    = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered port outputs; frozen while rdy_in is low.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            buf_q   <= 32'd0;
            a_q     <= '0;
            wr_q    <= 1'b0;
            dout_q  <= 8'd0;
        end else if (rdy_in) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            a_q     <= a_d;
            wr_q    <= wr_d;
            dout_q  <= dout_d;
        end
    end

    assign mem_a_out    = a_q;
    assign mem_wr_out   = wr_q;
    assign mem_dout_out = dout_q;

    // Stall, port ownership and writeback outputs; zero during reset.
    always_comb begin
        mem_req_out   = 1'b0;
        stall_req_out = 1'b0;
        rd_we_out     = 1'b0;
        rd_val_out    = 32'd0;
        rd_addr_out   = 5'd0;
        if (rst_in) begin
            rd_val_out  = rd_val_in;
            rd_addr_out = rd_addr_in;
            case (state_q)
                S_IDLE: begin
                    stall_req_out = is_ld || is_st;
                    rd_we_out     = rd_we_in && !(is_ld || is_st);
                end
                S_RUN, S_WAIT: begin
                    mem_req_out   = 1'b1;
                    stall_req_out = 1'b1;
                end
                S_DONE: begin
                    rd_we_out  = rd_we_in;
                    rd_val_out = is_ld ? ext : rd_val_in;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: RAM model plus scoreboard of writeback
// results, driven as a linear sequence of directed steps.
module tb_mem_stage;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        rd_we_in;
    logic [31:0] rd_val_in;
    logic [4:0]  rd_addr_in;
    logic [3:0]  mem_op_in;
    logic [31:0] mem_addr_in;
    logic [31:0] store_data_in;
    logic        mem_busy_in;
    logic [7:0]  mem_din_in = 8'd0;
    logic [31:0] mem_a_out;
    logic        mem_wr_out;
    logic [7:0]  mem_dout_out;
    logic        mem_req_out;
    logic        stall_req_out;
    logic        rd_we_out;
    logic [31:0] rd_val_out;
    logic [4:0]  rd_addr_out;

    typedef struct {
        logic [31:0] val;
        logic        we;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] a_log[$];
    logic [7:0]  ram[logic [31:0]];
    int          total = 0;
    int          bad = 0;
    int          nwr;
    int          st;

    mem_stage #(.ADDR_W(32)) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .rdy_in(rdy_in),
        .rd_we_in(rd_we_in),
        .rd_val_in(rd_val_in),
        .rd_addr_in(rd_addr_in),
        .mem_op_in(mem_op_in),
        .mem_addr_in(mem_addr_in),
        .store_data_in(store_data_in),
        .mem_busy_in(mem_busy_in),
        .mem_din_in(mem_din_in),
        .mem_a_out(mem_a_out),
        .mem_wr_out(mem_wr_out),
        .mem_dout_out(mem_dout_out),
        .mem_req_out(mem_req_out),
        .stall_req_out(stall_req_out),
        .rd_we_out(rd_we_out),
        .rd_val_out(rd_val_out),
        .rd_addr_out(rd_addr_out)
    );

    always #5 clk_in = ~clk_in;

    // Synchronous byte RAM, gated by the global ready like the pipeline.
    always @(posedge clk_in) begin
        if (rdy_in) begin
            mem_din_in <= ram.exists(mem_a_out) ? ram[mem_a_out] : 8'h00;
            if (mem_wr_out)
                ram[mem_a_out] = mem_dout_out;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rb(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    // Drive one memory op, count stall cycles, then score DONE.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] addr, input logic [31:0] sd,
                          input logic [31:0] rv, input logic we,
                          input int busy_n, input int rdy_at,
                          output int stalls);
        int   c;
        int   weviol;
        exp_t e;
        a_log.delete();
        nwr = 0;
        weviol = 0;
        mem_op_in = op;
        mem_addr_in = addr;
        store_data_in = sd;
        rd_val_in = rv;
        rd_we_in = we;
        rd_addr_in = 5'd9;
        mem_busy_in = (busy_n > 0);
        rdy_in = 1'b1;
        stalls = 0;
        for (c = 0; c < 60; c++) begin
            @(negedge clk_in);
            if (!stall_req_out) break;
            stalls++;
            if (rd_we_out !== 1'b0) weviol++;
            if (mem_req_out && rdy_in) a_log.push_back(mem_a_out);
            if (mem_wr_out && rdy_in) nwr++;
            @(posedge clk_in);
            #1;
            mem_busy_in = (c + 1 < busy_n);
            rdy_in = !(rdy_at > 0 && (c + 1 == rdy_at || c + 1 == rdy_at + 1));
        end
        chk({tag, "_timeout"}, (c < 60) ? 32'd1 : 32'd0, 32'd1);
        chk({tag, "_we_in_stall"}, weviol, 32'd0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_val"}, rd_val_out, e.val);
            chk({tag, "_we"}, {31'd0, rd_we_out}, {31'd0, e.we});
        end else begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end
        chk({tag, "_addr"}, {27'd0, rd_addr_out}, 32'd9);
        @(posedge clk_in);
        #1;
        mem_op_in = 4'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b0;
        rdy_in = 1'b1;
        rd_we_in = 1'b1;
        rd_val_in = 32'h1234;
        rd_addr_in = 5'd5;
        mem_op_in = 4'd0;
        mem_addr_in = 32'd0;
        store_data_in = 32'd0;
        mem_busy_in = 1'b0;
        ram[32'h100] = 8'h78;
        ram[32'h101] = 8'h56;
        ram[32'h102] = 8'h34;
        ram[32'h103] = 8'h12;
        ram[32'h200] = 8'h80;
        ram[32'h202] = 8'hFE;
        ram[32'h203] = 8'hFF;
        ram[32'h400] = 8'h11;
        ram[32'h401] = 8'h22;
        ram[32'h402] = 8'h33;
        ram[32'h403] = 8'h44;

        // reset state
        @(negedge clk_in);
        chk("rst_a", mem_a_out, 32'd0);
        chk("rst_wr", {31'd0, mem_wr_out}, 32'd0);
        chk("rst_dout", {24'd0, mem_dout_out}, 32'd0);
        chk("rst_we", {31'd0, rd_we_out}, 32'd0);
        chk("rst_val", rd_val_out, 32'd0);
        chk("rst_stall", {31'd0, stall_req_out}, 32'd0);

        // NONE pass-through
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        #1;
        chk("none_we", {31'd0, rd_we_out}, 32'd1);
        chk("none_addr", {27'd0, rd_addr_out}, 32'd5);
        chk("none_val", rd_val_out, 32'h1234);
        chk("none_stall", {31'd0, stall_req_out}, 32'd0);
        chk("none_wr", {31'd0, mem_wr_out}, 32'd0);
        @(posedge clk_in);
        #1;

        // LW
        sb.push_back('{32'h12345678, 1'b1});
        run_op("lw", 4'd3, 32'h100, 32'd0, 32'hAAAA, 1'b1, 0, 0, st);
        chk("lw_stall", st, 32'd6);
        for (int i = 0; i < 4; i++)
            chk($sformatf("lw_a%0d", i),
                (a_log.size() > i) ? a_log[i] : 32'hX, 32'h100 + i);

        // LB / LBU / LH
        sb.push_back('{32'hFFFFFF80, 1'b1});
        run_op("lb", 4'd1, 32'h200, 32'd0, 32'd0, 1'b1, 0, 0, st);
        chk("lb_stall", st, 32'd3);
        sb.push_back('{32'h00000080, 1'b1});
        run_op("lbu", 4'd4, 32'h200, 32'd0, 32'd0, 1'b1, 0, 0, st);
        sb.push_back('{32'hFFFFFFFE, 1'b1});
        run_op("lh", 4'd2, 32'h202, 32'd0, 32'd0, 1'b1, 0, 0, st);
        chk("lh_stall", st, 32'd4);

        // SW wrapping the top of memory
        sb.push_back('{32'h5555, 1'b0});
        run_op("sw", 4'd8, 32'hFFFFFFFE, 32'hDEADBEEF, 32'h5555, 1'b0,
               0, 0, st);
        chk("sw_stall", st, 32'd5);
        chk("sw_nwr", nwr, 32'd4);
        chk("sw_b0", {24'd0, rb(32'hFFFFFFFE)}, 32'hEF);
        chk("sw_b1", {24'd0, rb(32'hFFFFFFFF)}, 32'hBE);
        chk("sw_b2", {24'd0, rb(32'h0)}, 32'hAD);
        chk("sw_b3", {24'd0, rb(32'h1)}, 32'hDE);

        // SB with 3 busy cycles at start
        sb.push_back('{32'h77, 1'b0});
        run_op("sb", 4'd6, 32'h300, 32'h123456A5, 32'h77, 1'b0, 3, 0, st);
        chk("sb_stall", st, 32'd5);
        chk("sb_byte", {24'd0, rb(32'h300)}, 32'hA5);
        chk("sb_next", {24'd0, rb(32'h301)}, 32'h00);

        // LW with two not-ready cycles mid-transaction
        sb.push_back('{32'h44332211, 1'b1});
        run_op("lw_rdy", 4'd3, 32'h400, 32'd0, 32'd0, 1'b1, 0, 3, st);
        chk("lw_rdy_stall", st, 32'd8);

        // SH aborted by reset during its second byte
        mem_op_in = 4'd7;
        mem_addr_in = 32'h500;
        store_data_in = 32'h0000BBAA;
        rd_we_in = 1'b1;
        @(posedge clk_in);
        #1;
        @(posedge clk_in);
        #1;
        chk("sh_a1", mem_a_out, 32'h501);
        chk("sh_wr1", {31'd0, mem_wr_out}, 32'd1);
        rst_in = 1'b0;
        #1;
        chk("shr_a", mem_a_out, 32'd0);
        chk("shr_wr", {31'd0, mem_wr_out}, 32'd0);
        chk("shr_dout", {24'd0, mem_dout_out}, 32'd0);
        chk("shr_req", {31'd0, mem_req_out}, 32'd0);
        chk("shr_stall", {31'd0, stall_req_out}, 32'd0);
        chk("shr_we", {31'd0, rd_we_out}, 32'd0);
        chk("shr_val", rd_val_out, 32'd0);
        chk("shr_addr", {27'd0, rd_addr_out}, 32'd0);
        mem_op_in = 4'd0;
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("post_rst_stall", {31'd0, stall_req_out}, 32'd0);
        chk("post_rst_we", {31'd0, rd_we_out}, 32'd1);
        chk("sh_b0", {24'd0, rb(32'h500)}, 32'hAA);
        @(posedge clk_in);
        #1;

        // normal LW after the aborted store
        sb.push_back('{32'h12345678, 1'b1});
        run_op("lw2", 4'd3, 32'h100, 32'd0, 32'd0, 1'b1, 0, 0, st);
        chk("lw2_stall", st, 32'd6);
        chk("sb_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
